traffic_light_ctrl: RTL and testbench
=====================================

Name: traffic_light_ctrl

Overview:
- Sequences a two-road (north-south / east-west) traffic light at intersection level.
- Timebase is the 1 Hz square wave from the team's seconds divider, fed in on sec_clk. The block synchronises it, edge-detects it and derives a one-cycle seconds tick in the clk domain.
- A 6-state FSM with a per-phase seconds countdown drives both lamp sets and a remaining-seconds value for the 7-seg display.

Parameters:
- GREEN_S, 10, green phase length in seconds (legal range 1..2^CNT_W-1).
- YELLOW_S, 3, yellow phase length in seconds (legal range 1..2^CNT_W-1).
- CLR_S, 1, all-red clearance length in seconds (legal range 1..2^CNT_W-1).
- PED_MIN_S, 3, green seconds remaining after a pedestrian request is honoured; only used with PED_BUTTON_EN.
- CNT_W, 8, width of the seconds counter.

Ports:
- clk, input, 1, system clock (50 MHz board clock).
- rst, input, 1, asynchronous active-high reset.
- sec_clk, input, 1, 1 Hz square wave from the seconds divider; asynchronous to the FSM's view, so it is synchronised internally.
- enable, input, 1, 1 = run, 0 = freeze the sequence.
- ped_req, input, 1, pedestrian button (level or pulse, already debounced); ignored unless PED_BUTTON_EN is defined.
- ns_light, output, 3, NS lamps {R,Y,G}, one-hot.
- ew_light, output, 3, EW lamps {R,Y,G}, one-hot.
- sec_left, output, CNT_W, seconds remaining in the current phase.
- phase, output, 3, state encoding.
- sec_tick, output, 1, one-cycle seconds tick (debug / display strobe).

Behaviour:
- Tick generation:
  - sec_clk passes through 2 synchroniser flops s1, s2, then a delay flop s3; all three reset to 0.
  - sec_tick = s2 & ~s3 (combinational from registers).
  - A sec_clk rising edge produces sec_tick 2–3 clk cycles later, exactly one cycle wide, once per sec_clk period.
  - If sec_clk is high when rst deasserts, a tick is produced 2 cycles after release. This is accepted behaviour.
- States and encoding: CLR_A=0, NS_G=1, NS_Y=2, CLR_B=3, EW_G=4, EW_Y=5. Cyclic order CLR_A→NS_G→NS_Y→CLR_B→EW_G→EW_Y→CLR_A.
- Lamps, registered and decoded from state:
  - NS_G: ns=001, ew=100.
  - NS_Y: ns=010, ew=100.
  - EW_G: ns=100, ew=001.
  - EW_Y: ns=100, ew=010.
  - CLR_A/CLR_B: both 100.
  - Both greens or a green plus a yellow are never simultaneously lit.
  - Illegal state encodings (6, 7) go to CLR_A with sec_left=CLR_S on the next clk.
- Reset: phase=CLR_A, sec_left=CLR_S, ns_light=ew_light=100, sec_tick=0.
- Countdown, applied on a clk edge where sec_tick=1 and enable=1:
  - If sec_left>1: sec_left-1.
  - If sec_left==1: advance to the next state and load that phase's duration (GREEN_S / YELLOW_S / CLR_S) in the same edge.
  - sec_left therefore never shows 0; it counts N..1.
- Latency: state, lamps and sec_left update on the clk edge that samples sec_tick=1; visible 1 cycle after the tick.
- enable=0: ticks are ignored; state, sec_left and lamps hold. Resuming continues from the held value, with no extra decrement.
- Full cycle length: 2*(GREEN_S+YELLOW_S+CLR_S) ticks.
- rst mid-phase: immediate return to reset values regardless of clk.
- Synthesis-time check: a duration parameter of 0 or ≥2^CNT_W is illegal and must raise $error.

Optional Feature:
- Macro: PED_BUTTON_EN.
- Defined:
  - ped_req=1 sampled on any clk sets ped_pending.
  - On a tick while in NS_G or EW_G with ped_pending=1 and sec_left>PED_MIN_S+1: sec_left loads PED_MIN_S instead of decrementing.
  - ped_pending clears on entry to CLR_A or CLR_B.
  - A request made during a yellow or clearance phase shortens the next green.
  - A request together with rst is lost.
- Not defined: ped_req is unconnected internally, there is no ped_pending flop, and timing is purely parametric.

Test Plan:
- Bench settings: GREEN_S=4, YELLOW_S=2, CLR_S=1, sec_clk period 20 clk.
- Reset then 14 ticks → phase sequence 0,1,1,1,1,2,2,3,4,4,4,4,5,5, back to 0. sec_left sequence 1,4,3,2,1,2,1,1,4,3,2,1,2,1. Lamps match the decode table at every step.
- sec_clk held high 100 cycles, then low → exactly 1 sec_tick pulse, 1 cycle wide, 2–3 cycles after the rising edge.
- In NS_G with sec_left=3, enable=0 for 5 sec_clk periods → phase=1, sec_left=3 held. enable=1 → next tick gives sec_left=2.
- rst asserted asynchronously mid-EW_Y (between clk edges) → outputs at reset values immediately. After release, the first transition to NS_G happens on the 1st tick.
- PED_BUTTON_EN, GREEN_S=10, PED_MIN_S=3: ped_req pulse at NS_G sec_left=9 → next tick sec_left=3, then 2, 1, then NS_Y. A request at sec_left=4 → normal decrement to 3, with no reload.
- Lamp-safety assertion over a 1000-tick random enable/ped_req run → never ns_light[0] & ew_light[0], never any green with the other road not red.

Source files
------------

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-road (NS / EW) intersection light sequencer.
//
// A 1 Hz square wave (sec_clk) is synchronised into the clk domain and
// edge-detected into a one-cycle seconds tick. A 6-state FSM with a
// per-phase seconds countdown drives both lamp sets and the remaining-seconds
// value for the display.
//
// Optional feature macro: PED_BUTTON_EN (pedestrian request shortens green).
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   sec_clk   in   1 Hz square wave, asynchronous to clk
//   enable    in   1 = run, 0 = freeze the sequence
//   ped_req   in   pedestrian request (used only with PED_BUTTON_EN)
//   ns_light  out  NS lamps {R,Y,G}, one-hot, registered
//   ew_light  out  EW lamps {R,Y,G}, one-hot, registered
//   sec_left  out  seconds remaining in the current phase (N..1)
//   phase     out  state encoding
//   sec_tick  out  one-cycle seconds tick, decoded from synchroniser flops
module traffic_light_ctrl #(
  parameter int unsigned GREEN_S   = 10,
  parameter int unsigned YELLOW_S  = 3,
  parameter int unsigned CLR_S     = 1,
  parameter int unsigned PED_MIN_S = 3,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sec_clk,
  input  logic             enable,
  input  logic             ped_req,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic [CNT_W-1:0] sec_left,
  output logic [2:0]       phase,
  output logic             sec_tick
);

  localparam logic [63:0] MAX_S = (64'd1 << CNT_W) - 64'd1;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  // Elaboration-time range check on the phase durations
  if (GREEN_S == 0 || 64'(GREEN_S) > MAX_S) begin : g_bad_green
    $error("traffic_light_ctrl: GREEN_S out of range 1..2^CNT_W-1");
  end
  if (YELLOW_S == 0 || 64'(YELLOW_S) > MAX_S) begin : g_bad_yellow
    $error("traffic_light_ctrl: YELLOW_S out of range 1..2^CNT_W-1");
  end
  if (CLR_S == 0 || 64'(CLR_S) > MAX_S) begin : g_bad_clr
    $error("traffic_light_ctrl: CLR_S out of range 1..2^CNT_W-1");
  end

  typedef enum logic [2:0] {
    CLR_A = 3'd0,
    NS_G  = 3'd1,
    NS_Y  = 3'd2,
    CLR_B = 3'd3,
    EW_G  = 3'd4,
    EW_Y  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic [2:0]       ns_d, ew_d;
  logic             s1, s2, s3;
  logic             tick_en;
  logic             ped_cut;

  // Two-flop synchroniser plus delay flop for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sec_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sec_tick = s2 & ~s3;
  assign tick_en  = sec_tick & enable;

  function automatic logic [CNT_W-1:0] phase_len(input state_t s);
    case (s)
      NS_G, EW_G: phase_len = CNT_W'(GREEN_S);
      NS_Y, EW_Y: phase_len = CNT_W'(YELLOW_S);
      default:    phase_len = CNT_W'(CLR_S);
    endcase
  endfunction

  function automatic state_t succ(input state_t s);
    case (s)
      CLR_A:   succ = NS_G;
      NS_G:    succ = NS_Y;
      NS_Y:    succ = CLR_B;
      CLR_B:   succ = EW_G;
      EW_G:    succ = EW_Y;
      default: succ = CLR_A;
    endcase
  endfunction

`ifdef PED_BUTTON_EN
  logic ped_pending;
  logic entering_clr;

  assign entering_clr = (state_d != state_q) && (state_d == CLR_A || state_d == CLR_B);

  // A fresh request outranks the clear so a request made on the yellow-to-clear
  // edge still shortens the following green.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ped_pending <= 1'b0;
    end else if (ped_req) begin
      ped_pending <= 1'b1;
    end else if (entering_clr) begin
      ped_pending <= 1'b0;
    end
  end

  assign ped_cut = ped_pending && (state_q == NS_G || state_q == EW_G) &&
                   (64'(left_q) > 64'(PED_MIN_S) + 64'd1);
`else
  logic unused_ped;
  assign unused_ped = ^{ped_req, 32'(PED_MIN_S)};
  assign ped_cut    = 1'b0;
`endif

  // Next state / countdown
  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    case (state_q)
      CLR_A, NS_G, NS_Y, CLR_B, EW_G, EW_Y: begin
        if (tick_en) begin
          if (left_q > CNT_W'(1)) begin
            left_d = ped_cut ? CNT_W'(PED_MIN_S) : left_q - CNT_W'(1);
          end else begin
            state_d = succ(state_q);
            left_d  = phase_len(succ(state_q));
          end
        end
      end
      default: begin
        state_d = CLR_A;
        left_d  = CNT_W'(CLR_S);
      end
    endcase
  end

  // Lamp decode from the next state so lamps change on the same edge as phase
  always_comb begin
    ns_d = LAMP_R;
    ew_d = LAMP_R;
    case (state_d)
      NS_G:    ns_d = LAMP_G;
      NS_Y:    ns_d = LAMP_Y;
      EW_G:    ew_d = LAMP_G;
      EW_Y:    ew_d = LAMP_Y;
      default: begin
        ns_d = LAMP_R;
        ew_d = LAMP_R;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= CLR_A;
      left_q   <= CNT_W'(CLR_S);
      ns_light <= LAMP_R;
      ew_light <= LAMP_R;
    end else begin
      state_q  <= state_d;
      left_q   <= left_d;
      ns_light <= ns_d;
      ew_light <= ew_d;
    end
  end

  assign sec_left = left_q;
  assign phase    = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Testbench for traffic_light_ctrl: directed and random seconds against a
// phase-table reference model.
module tb_traffic_light_ctrl;

`ifdef PED_BUTTON_EN
  localparam int unsigned G = 10;
`else
  localparam int unsigned G = 4;
`endif
  localparam int unsigned Y = 2;
  localparam int unsigned C = 1;
  localparam int unsigned P = 3;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         sec_clk;
  logic         enable;
  logic         ped_req;
  logic [2:0]   ns_light;
  logic [2:0]   ew_light;
  logic [W-1:0] sec_left;
  logic [2:0]   phase;
  logic         sec_tick;

  always #5 clk = ~clk;

  traffic_light_ctrl #(
    .GREEN_S(G), .YELLOW_S(Y), .CLR_S(C), .PED_MIN_S(P), .CNT_W(W)
  ) dut (
    .clk(clk), .rst(rst), .sec_clk(sec_clk), .enable(enable), .ped_req(ped_req),
    .ns_light(ns_light), .ew_light(ew_light), .sec_left(sec_left),
    .phase(phase), .sec_tick(sec_tick)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: phase index into the cyclic order and seconds left
  int         m_idx;
  int         m_left;
  bit         m_pend;
  int         dur_tab[6]    = '{C, G, Y, C, G, Y};
  logic [2:0] ns_tab[6]     = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
  logic [2:0] ew_tab[6]     = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010};
  int         exp_ph[15]    = '{0, 1, 1, 1, 1, 2, 2, 3, 4, 4, 4, 4, 5, 5, 0};
  int         exp_left[15]  = '{1, 4, 3, 2, 1, 2, 1, 1, 4, 3, 2, 1, 2, 1, 1};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_idx  = 0;
    m_left = C;
    m_pend = 0;
  endtask

  task automatic model_sec(input bit en, input bit ped);
    bit cut;
    cut = 0;
`ifdef PED_BUTTON_EN
    if (ped) m_pend = 1;
`endif
    if (en) begin
      if (m_left > 1) begin
`ifdef PED_BUTTON_EN
        cut = m_pend && (m_idx == 1 || m_idx == 4) && (m_left > int'(P) + 1);
`endif
        if (cut) m_left = P;
        else     m_left = m_left - 1;
      end else begin
        m_idx  = (m_idx + 1) % 6;
        m_left = dur_tab[m_idx];
        if (m_idx == 0 || m_idx == 3) m_pend = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".phase"}, 64'(phase), 64'(m_idx));
    check({tag, ".left"},  64'(sec_left), 64'(m_left));
    check({tag, ".ns"},    64'(ns_light), 64'(ns_tab[m_idx]));
    check({tag, ".ew"},    64'(ew_light), 64'(ew_tab[m_idx]));
  endtask

  // One sec_clk period starting at posedge+1; ends at posedge+1
  task automatic one_sec(input bit en, input bit ped, input int high_cycles);
    int  ticks;
    int  first;
    bit  safe;
    ticks   = 0;
    first   = -1;
    enable  = en;
    ped_req = ped;
    sec_clk = 1'b1;
    for (int i = 1; i <= high_cycles + 10; i++) begin
      @(posedge clk);
      #1;
      ped_req = 1'b0;
      if (i == high_cycles) sec_clk = 1'b0;
      if (sec_tick) begin
        ticks++;
        if (first < 0) first = i;
      end
      safe = !(ns_light[0] && ew_light != 3'b100) && !(ew_light[0] && ns_light != 3'b100);
      check("lamp_safety", 64'(safe), 64'd1);
    end
    check("tick_count", 64'(ticks), 64'd1);
    check("tick_pos", 64'(first), 64'd2);
    model_sec(en, ped);
    check_model("sec");
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".phase"}, 64'(phase), 64'd0);
    check({tag, ".left"},  64'(sec_left), 64'(C));
    check({tag, ".ns"},    64'(ns_light), 64'(3'b100));
    check({tag, ".ew"},    64'(ew_light), 64'(3'b100));
    check({tag, ".tick"},  64'(sec_tick), 64'd0);
  endtask

  initial begin
    int reached;
    rst     = 1'b1;
    sec_clk = 1'b0;
    enable  = 1'b1;
    ped_req = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;

`ifndef PED_BUTTON_EN
    // Full cycle against the documented sequence
    check("seq0.phase", 64'(phase), 64'(exp_ph[0]));
    check("seq0.left",  64'(sec_left), 64'(exp_left[0]));
    for (int k = 1; k <= 14; k++) begin
      one_sec(1'b1, 1'b0, 10);
      check("seq.phase", 64'(phase), 64'(exp_ph[k]));
      check("seq.left",  64'(sec_left), 64'(exp_left[k]));
    end
`endif

    // Long-high sec_clk still yields a single tick
    one_sec(1'b1, 1'b0, 100);

    // Freeze in NS_G at 3 seconds left
    reached = 0;
    for (int k = 0; k < 40 && !reached; k++) begin
      if (m_idx == 1 && m_left == 3) reached = 1;
      else one_sec(1'b1, 1'b0, 10);
    end
    check("reach_nsg3", 64'(reached), 64'd1);
    for (int k = 0; k < 5; k++) one_sec(1'b0, 1'b0, 10);
    check("freeze.phase", 64'(phase), 64'd1);
    check("freeze.left",  64'(sec_left), 64'd3);
    one_sec(1'b1, 1'b0, 10);
    check("resume.left",  64'(sec_left), 64'd2);

`ifdef PED_BUTTON_EN
    // Request at 9 seconds left cuts green to PED_MIN_S
    reached = 0;
    for (int k = 0; k < 60 && !reached; k++) begin
      if (m_idx == 1 && m_left == 9) reached = 1;
      else one_sec(1'b1, 1'b0, 10);
    end
    check("reach_nsg9", 64'(reached), 64'd1);
    one_sec(1'b1, 1'b1, 10);
    check("ped.cut", 64'(sec_left), 64'd3);
    one_sec(1'b1, 1'b0, 10);
    check("ped.2", 64'(sec_left), 64'd2);
    one_sec(1'b1, 1'b0, 10);
    check("ped.1", 64'(sec_left), 64'd1);
    one_sec(1'b1, 1'b0, 10);
    check("ped.yellow", 64'(phase), 64'd2);
    // Request at PED_MIN_S+1 left decrements normally
    reached = 0;
    for (int k = 0; k < 60 && !reached; k++) begin
      if (m_idx == 4 && m_left == 4) reached = 1;
      else one_sec(1'b1, 1'b0, 10);
    end
    check("reach_ewg4", 64'(reached), 64'd1);
    one_sec(1'b1, 1'b1, 10);
    check("ped.nocut", 64'(sec_left), 64'd3);
`endif

    // Asynchronous reset in the middle of EW_Y, between clock edges
    reached = 0;
    for (int k = 0; k < 60 && !reached; k++) begin
      if (m_idx == 5) reached = 1;
      else one_sec(1'b1, 1'b0, 10);
    end
    check("reach_ewy", 64'(reached), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    one_sec(1'b1, 1'b0, 10);
    check("post_rst.phase", 64'(phase), 64'd1);
    check("post_rst.left",  64'(sec_left), 64'(G));

    // Random enable / pedestrian run
    for (int k = 0; k < 1000; k++) begin
      one_sec(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), 10);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
